// File: rtl/hazard_scoreboard_unit.sv
// Hazard control for the 5-stage core: EX forwarding, load-use and multi-cycle
// scoreboard stalls, redirect flushes and a saturating stall-cycle counter.
module hazard_scoreboard_unit #(
    parameter int RW       = 5,
    parameter int NUM_REGS = 32,
    parameter int MC_LAT   = 4,
    parameter int CW       = 3,
    parameter int SCW      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RW-1:0]       Rs1D,
    input  logic [RW-1:0]       Rs2D,
    input  logic [RW-1:0]       RdD,
    input  logic                useRs1D,
    input  logic                useRs2D,
    input  logic                regWriteD,
    input  logic                mcOpD,
    input  logic [RW-1:0]       Rs1E,
    input  logic [RW-1:0]       Rs2E,
    input  logic [RW-1:0]       RdE,
    input  logic                regWriteE,
    input  logic                loadE,
    input  logic                mcOpE,
    input  logic [1:0]          PCSrcE,
    input  logic [RW-1:0]       RdM,
    input  logic                regWriteM,
    input  logic [RW-1:0]       RdW,
    input  logic                regWriteW,
    output logic                stallF,
    output logic                stallD,
    output logic                flushD,
    output logic                flushE,
    output logic [1:0]          forwardAE,
    output logic [1:0]          forwardBE,
    output logic                mcBusy,
    output logic [NUM_REGS-1:0] pendingMask,
    output logic [SCW-1:0]      stallCount
);

    localparam logic [RW-1:0]  REG_ZERO = {RW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [SCW-1:0] SC_MAX   = {SCW{1'b1}};

    logic [CW-1:0]       mcCnt_r;
    logic [RW-1:0]       rdInFlight_r;
    logic [NUM_REGS-1:0] pendingMask_r;
    logic [NUM_REGS-1:0] pendNext_s;
    logic [SCW-1:0]      stallCount_r;
    logic                loadUse_s;
    logic                sbRaw_s;
    logic                sbWaw_s;
    logic                structural_s;
    logic                hz_s;
    logic                redirect_s;

    // M-stage result is younger than W, so it takes priority
    function automatic logic [1:0] fwdSel(
        input logic [RW-1:0] src,
        input logic          wrM,
        input logic [RW-1:0] rdM,
        input logic          wrW,
        input logic [RW-1:0] rdW
    );
        logic [1:0] sel;
        if (wrM && (rdM != REG_ZERO) && (rdM == src)) begin
            sel = 2'b10;
        end else if (wrW && (rdW != REG_ZERO) && (rdW == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding selects and hazard detection
    always_comb begin
        forwardAE    = fwdSel(Rs1E, regWriteM, RdM, regWriteW, RdW);
        forwardBE    = fwdSel(Rs2E, regWriteM, RdM, regWriteW, RdW);
        loadUse_s    = loadE && regWriteE && (RdE != REG_ZERO) &&
                       ((useRs1D && (Rs1D == RdE)) || (useRs2D && (Rs2D == RdE)));
        sbRaw_s      = (useRs1D && pendingMask_r[Rs1D]) || (useRs2D && pendingMask_r[Rs2D]);
        sbWaw_s      = regWriteD && (RdD != REG_ZERO) && pendingMask_r[RdD];
        structural_s = mcOpD && (mcCnt_r > CNT_ONE);
        hz_s         = loadUse_s | sbRaw_s | sbWaw_s | structural_s;
        redirect_s   = (PCSrcE != 2'b00);
    end

    // Redirect squashes the wrong-path instructions and overrides any stall
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (redirect_s) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else begin
            stallF = hz_s;
            stallD = hz_s;
            flushE = hz_s;
        end
    end

    // Next scoreboard: retire clear first so a same-register issue wins
    always_comb begin
        pendNext_s = pendingMask_r;
        if (mcCnt_r == CNT_ONE) begin
            pendNext_s[rdInFlight_r] = 1'b0;
        end else begin
            pendNext_s = pendingMask_r;
        end
        if (mcOpE && (RdE != REG_ZERO)) begin
            pendNext_s[RdE] = 1'b1;
        end else begin
            pendNext_s = pendNext_s;
        end
        pendNext_s[0] = 1'b0;
    end

    // Multi-cycle latency counter, in-flight destination and scoreboard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcCnt_r       <= {CW{1'b0}};
            rdInFlight_r  <= REG_ZERO;
            pendingMask_r <= {NUM_REGS{1'b0}};
        end else begin
            pendingMask_r <= pendNext_s;
            if (mcOpE) begin
                mcCnt_r      <= CW'(MC_LAT);
                rdInFlight_r <= RdE;
            end else if (mcCnt_r != {CW{1'b0}}) begin
                mcCnt_r <= mcCnt_r - CNT_ONE;
            end else begin
                mcCnt_r <= mcCnt_r;
            end
        end
    end

    // Saturating count of decode stall cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount_r <= {SCW{1'b0}};
        end else if (stallD && (stallCount_r != SC_MAX)) begin
            stallCount_r <= stallCount_r + SCW'(1);
        end else begin
            stallCount_r <= stallCount_r;
        end
    end

    assign mcBusy      = (mcCnt_r != {CW{1'b0}});
    assign pendingMask = pendingMask_r;
    assign stallCount  = stallCount_r;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: a behavioural model checked
// every cycle plus directed vectors with hand-computed literal expectations.
module tb_hazard_scoreboard_unit;

    localparam int RW = 5;
    localparam int NR = 32;
    localparam int LAT = 4;
    localparam int SCW = 16;

    logic clk = 1'b0;
    logic rst;
    logic [RW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
    logic useRs1D, useRs2D, regWriteD, mcOpD, regWriteE, loadE, mcOpE, regWriteM, regWriteW;
    logic [1:0] PCSrcE;
    logic stallF, stallD, flushD, flushE, mcBusy;
    logic [1:0] forwardAE, forwardBE;
    logic [NR-1:0] pendingMask;
    logic [SCW-1:0] stallCount;

    int nChecks = 0;
    int nFails = 0;

    // Model state: remaining cycles of the unit, its destination, pending set, stall total
    int mRemain;
    int mRd;
    bit mPend [NR];
    int mStalls;

    hazard_scoreboard_unit dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .useRs1D(useRs1D), .useRs2D(useRs2D), .regWriteD(regWriteD), .mcOpD(mcOpD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .regWriteE(regWriteE), .loadE(loadE), .mcOpE(mcOpE), .PCSrcE(PCSrcE),
        .RdM(RdM), .regWriteM(regWriteM), .RdW(RdW), .regWriteW(regWriteW),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mcBusy(mcBusy), .pendingMask(pendingMask), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int expFwd(input int src);
        if (regWriteM && RdM != 0 && int'(RdM) == src) return 2;
        if (regWriteW && RdW != 0 && int'(RdW) == src) return 1;
        return 0;
    endfunction

    function automatic bit expHazard();
        bit lu, raw, waw, st;
        lu  = loadE && regWriteE && RdE != 0 &&
              ((useRs1D && Rs1D == RdE) || (useRs2D && Rs2D == RdE));
        raw = (useRs1D && mPend[Rs1D]) || (useRs2D && mPend[Rs2D]);
        waw = regWriteD && RdD != 0 && mPend[RdD];
        st  = mcOpD && mRemain >= 2;
        return lu || raw || waw || st;
    endfunction

    function automatic bit expStall();
        return (PCSrcE == 2'b00) && expHazard();
    endfunction

    function automatic logic [31:0] pendWord();
        logic [31:0] w;
        w = 32'd0;
        for (int i = 1; i < NR; i++) w[i] = mPend[i];
        return w;
    endfunction

    // Model update on each edge; the unit result retires when one cycle remains
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mRemain <= 0;
            mRd <= 0;
            mStalls <= 0;
            for (int i = 0; i < NR; i++) mPend[i] <= 1'b0;
        end else begin
            if (expStall() && mStalls < 65535) mStalls <= mStalls + 1;
            for (int i = 1; i < NR; i++) begin
                if (mcOpE && int'(RdE) == i) mPend[i] <= 1'b1;
                else if (mRemain == 1 && mRd == i) mPend[i] <= 1'b0;
            end
            if (mcOpE) begin
                mRemain <= LAT;
                mRd <= int'(RdE);
            end else if (mRemain > 0) begin
                mRemain <= mRemain - 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_forwardAE", 32'(forwardAE), 32'(expFwd(int'(Rs1E))));
            chk("m_forwardBE", 32'(forwardBE), 32'(expFwd(int'(Rs2E))));
            chk("m_stallF", 32'(stallF), 32'(expStall()));
            chk("m_stallD", 32'(stallD), 32'(expStall()));
            chk("m_flushD", 32'(flushD), 32'(PCSrcE != 2'b00));
            chk("m_flushE", 32'(flushE), 32'((PCSrcE != 2'b00) || expHazard()));
            chk("m_mcBusy", 32'(mcBusy), 32'(mRemain != 0));
            chk("m_pendingMask", 32'(pendingMask), pendWord());
            chk("m_stallCount", 32'(stallCount), 32'(mStalls));
        end
    end

    task automatic clr();
        Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        useRs1D = 1'b0; useRs2D = 1'b0; regWriteD = 1'b0; mcOpD = 1'b0;
        regWriteE = 1'b0; loadE = 1'b0; mcOpE = 1'b0; PCSrcE = 2'b00;
        regWriteM = 1'b0; regWriteW = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [SCW-1:0] scSave;
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_pendingMask", 32'(pendingMask), 32'd0);
        chk("rst_mcBusy", 32'(mcBusy), 32'd0);
        chk("rst_stallCount", 32'(stallCount), 32'd0);
        chk("rst_stallD", 32'(stallD), 32'd0);

        // Forwarding priority
        cyc();
        regWriteM = 1'b1; RdM = 5'd5; regWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5;
        #1 chk("fwdA_M", 32'(forwardAE), 32'd2);
        chk("fwdB_M", 32'(forwardBE), 32'd2);
        cyc();
        regWriteM = 1'b0;
        #1 chk("fwdA_W", 32'(forwardAE), 32'd1);
        cyc();
        regWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0;
        #1 chk("fwdA_x0", 32'(forwardAE), 32'd0);

        // Load-use
        cyc();
        clr();
        loadE = 1'b1; regWriteE = 1'b1; RdE = 5'd7; useRs2D = 1'b1; Rs2D = 5'd7;
        #1 chk("lu_stallF", 32'(stallF), 32'd1);
        chk("lu_stallD", 32'(stallD), 32'd1);
        chk("lu_flushE", 32'(flushE), 32'd1);
        chk("lu_flushD", 32'(flushD), 32'd0);
        chk("lu_count0", 32'(stallCount), 32'd0);
        cyc();
        clr();
        #1 chk("lu_count1", 32'(stallCount), 32'd1);
        chk("lu_release", 32'(stallD), 32'd0);

        // Scoreboard RAW over the full latency
        mcOpE = 1'b1; RdE = 5'd9; regWriteE = 1'b1;
        cyc();
        clr();
        useRs1D = 1'b1; Rs1D = 5'd9;
        #1 chk("raw_pend9", 32'(pendingMask[9]), 32'd1);
        chk("raw_busy", 32'(mcBusy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("raw_stall", 32'(stallD), 32'd1);
            cyc();
        end
        chk("raw_release", 32'(stallD), 32'd0);
        chk("raw_cleared", 32'(pendingMask), 32'd0);
        chk("raw_count", 32'(stallCount), 32'd5);

        // Structural and WAW
        clr();
        mcOpE = 1'b1; RdE = 5'd9;
        cyc();
        mcOpE = 1'b0;
        cyc();
        mcOpD = 1'b1; regWriteD = 1'b1; RdD = 5'd3;
        #1 chk("st_cnt3", 32'(stallD), 32'd1);
        cyc();
        chk("st_cnt2", 32'(stallD), 32'd1);
        cyc();
        chk("st_cnt1", 32'(stallD), 32'd0);
        mcOpD = 1'b0; RdD = 5'd9;
        #1 chk("waw_stall", 32'(stallD), 32'd1);
        cyc();
        chk("waw_release", 32'(stallD), 32'd0);
        clr();
        mcOpE = 1'b1; RdE = 5'd0;
        cyc();
        clr();
        #1 chk("x0_busy", 32'(mcBusy), 32'd1);
        chk("x0_mask", 32'(pendingMask), 32'd0);
        repeat (4) cyc();

        // Redirect dominates a load-use stall
        loadE = 1'b1; regWriteE = 1'b1; RdE = 5'd7; useRs1D = 1'b1; Rs1D = 5'd7; PCSrcE = 2'b01;
        scSave = stallCount;
        #1 chk("rd_stallF", 32'(stallF), 32'd0);
        chk("rd_stallD", 32'(stallD), 32'd0);
        chk("rd_flushD", 32'(flushD), 32'd1);
        chk("rd_flushE", 32'(flushE), 32'd1);
        cyc();
        chk("rd_count", 32'(stallCount), 32'(scSave));

        // Pseudo-random traffic against the model
        for (int i = 0; i < 300; i++) begin
            clr();
            Rs1D = 5'($urandom_range(0, 11)); Rs2D = 5'($urandom_range(0, 11));
            RdD = 5'($urandom_range(0, 11));  Rs1E = 5'($urandom_range(0, 7));
            Rs2E = 5'($urandom_range(0, 7));  RdE = 5'($urandom_range(0, 11));
            RdM = 5'($urandom_range(0, 7));   RdW = 5'($urandom_range(0, 7));
            useRs1D = 1'($urandom); useRs2D = 1'($urandom); regWriteD = 1'($urandom);
            mcOpD = 1'($urandom); regWriteE = 1'($urandom); loadE = 1'($urandom);
            mcOpE = ($urandom_range(0, 5) == 0);
            PCSrcE = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            regWriteM = 1'($urandom); regWriteW = 1'($urandom);
            cyc();
        end

        // Asynchronous reset mid-cycle with a result in flight
        clr();
        mcOpE = 1'b1; RdE = 5'd9;
        cyc();
        clr();
        repeat (2) cyc();
        chk("ar_busy_pre", 32'(mcBusy), 32'd1);
        chk("ar_pend_pre", 32'(pendingMask[9]), 32'd1);
        #2 rst = 1'b1;
        #1 chk("ar_busy", 32'(mcBusy), 32'd0);
        chk("ar_mask", 32'(pendingMask), 32'd0);
        chk("ar_count", 32'(stallCount), 32'd0);
        cyc();
        rst = 1'b0;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the pipeline hazard logic of the 5-stage RISC-V core.
- Generalises register-address width and register count.
- Adds a per-register scoreboard and occupancy counter for one fixed-latency multi-cycle execution unit (mul/div), which the current core lacks.
- Combines EX-stage forwarding, load-use and scoreboard stalls, redirect flushes, and a saturating stall-cycle counter.
- Sits beside the datapath and drives its stall, flush and forward controls.

Parameters:
RW, 5, register address width
NUM_REGS, 32, architectural register count (2**RW)
MC_LAT, 4, multi-cycle unit latency in cycles from issue in EX to writeback; must be >= 2
CW, 3, counter width, must hold MC_LAT
SCW, 16, stall-cycle counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
Rs1D  in  RW  decode source 1
Rs2D  in  RW  decode source 2
RdD  in  RW  decode destination
useRs1D  in  1  decode instruction reads Rs1
useRs2D  in  1  decode instruction reads Rs2
regWriteD  in  1  decode instruction writes Rd
mcOpD  in  1  decode instruction is multi-cycle
Rs1E  in  RW  execute source 1
Rs2E  in  RW  execute source 2
RdE  in  RW  execute destination
regWriteE  in  1  execute writes Rd
loadE  in  1  execute instruction is a load
mcOpE  in  1  execute instruction issues to the multi-cycle unit this cycle
PCSrcE  in  2  nonzero = control redirect from EX
RdM  in  RW  memory-stage destination
regWriteM  in  1  memory-stage write enable
RdW  in  RW  writeback-stage destination
regWriteW  in  1  writeback-stage write enable
stallF  out  1  hold PC
stallD  out  1  hold IF/ID
flushD  out  1  clear IF/ID
flushE  out  1  clear ID/EX
forwardAE  out  2  SrcA select: 00 RF, 01 W result, 10 M result
forwardBE  out  2  SrcB select, same encoding
mcBusy  out  1  multi-cycle unit occupied
pendingMask  out  NUM_REGS  scoreboard, bit i = register i awaiting multi-cycle result
stallCount  out  SCW  saturating count of stallD cycles

Behaviour:
Reset: rst asserted at any time, including mid-operation, immediately clears the following to 0:
- internal latency counter mcCnt
- pendingMask
- stallCount

With no other activity, all outputs are 0 after reset.

Forwarding (combinational):
- forwardAE = 10 if regWriteM && RdM!=0 && RdM==Rs1E.
- Otherwise 01 if regWriteW && RdW!=0 && RdW==Rs1E.
- Otherwise 00.
- M has priority over W. forwardBE is identical using Rs2E.

Hazard terms:
- loadUse: loadE && regWriteE && RdE!=0 && ((useRs1D && Rs1D==RdE) || (useRs2D && Rs2D==RdE)).
- sbRAW: (useRs1D && pendingMask[Rs1D]) || (useRs2D && pendingMask[Rs2D]).
- sbWAW: regWriteD && RdD!=0 && pendingMask[RdD].
- structural: mcOpD && mcCnt>1.
- hz = loadUse | sbRAW | sbWAW | structural.

Stall/flush outputs:
- redirect = (PCSrcE!=0).
- When redirect: stallF=stallD=0 and flushD=flushE=1. Redirect dominates all stalls.
- Otherwise: stallF=stallD=hz, flushE=hz, flushD=0.

Scoreboard, per rising edge:
- If mcOpE: mcCnt <= MC_LAT, and pendingMask[RdE] <= 1 when RdE!=0.
- Else if mcCnt!=0: mcCnt <= mcCnt-1.
- When mcCnt==1 at the edge, pendingMask[rdInFlight] <= 0. rdInFlight is an internal register latched with RdE on issue.
- Clear and new issue on the same edge: both apply; if the registers are the same, the set wins.
- mcOpE is accepted even if redirect is asserted in the same cycle, because the EX instruction is architecturally valid.
- pendingMask[0] is always 0.
- mcBusy = (mcCnt!=0).

Writeback coupling: the datapath writes the multi-cycle result to the RF on the edge where mcCnt goes 1→0. The RF is write-before-read, so a decode instruction unstalled by that clear reads the correct value.

stallCount: increments on each edge where stallD=1, saturating at all-ones.

Test Plan:
- Forwarding: regWriteM=1, RdM=5, regWriteW=1, RdW=5, Rs1E=5 -> forwardAE=10. Drop regWriteM -> 01. Set RdM=RdW=0 with Rs1E=0 -> 00.
- Load-use: loadE=1, regWriteE=1, RdE=7, useRs2D=1, Rs2D=7 -> stallF=stallD=flushE=1, flushD=0 for one cycle; stallCount 0→1.
- Scoreboard RAW, MC_LAT=4: mcOpE with RdE=9 -> pendingMask[9]=1, mcBusy=1. Decode reads x9 -> stallD held 4 cycles; pendingMask[9]=0 and stallD=0 on the 5th cycle.
- Structural + WAW: second mcOpD while mcCnt=3 -> stall until mcCnt=1. regWriteD with RdD=9 while x9 pending -> stall. mcOpE with RdE=0 -> mcBusy=1, pendingMask stays all-zero.
- Redirect priority: loadUse true and PCSrcE=01 same cycle -> stallF=stallD=0, flushD=flushE=1, stallCount unchanged.
- Async reset: assert rst with mcCnt=2 and pendingMask[9]=1, between clock edges -> mcBusy, pendingMask and stallCount go to 0 immediately without a clock edge.
